// File: rtl/riv_timer_bank.sv
// Bank of N_CH independent down-counters with one-shot or periodic reload.
// Each channel exposes its live count, a zero-level flag and a one-cycle expiry pulse.
module riv_timer_bank #(
    parameter int WIDTH = 16,
    parameter int N_CH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         load,
    input  logic [N_CH*WIDTH-1:0]   value,
    input  logic [N_CH-1:0]         enable,
    input  logic [N_CH-1:0]         auto_reload,
    output logic [N_CH*WIDTH-1:0]   count,
    output logic [N_CH-1:0]         done,
    output logic [N_CH-1:0]         expire,
    output logic                    any_done
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q  [N_CH];
    logic [WIDTH-1:0] count_d  [N_CH];
    logic [WIDTH-1:0] reload_q [N_CH];
    logic [WIDTH-1:0] reload_d [N_CH];
    logic [N_CH-1:0]  expire_q;
    logic [N_CH-1:0]  expire_d;

    // Next-state per channel: load beats enable; a zero count either reloads or parks at zero.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            count_d[i]  = count_q[i];
            reload_d[i] = reload_q[i];
            expire_d[i] = 1'b0;
            if (load[i]) begin
                count_d[i]  = value[i*WIDTH +: WIDTH];
                reload_d[i] = value[i*WIDTH +: WIDTH];
            end else if (enable[i]) begin
                if (count_q[i] != CNT_ZERO) begin
                    count_d[i]  = count_q[i] - CNT_ONE;
                    // Pulse lands in the cycle the count first reads zero.
                    expire_d[i] = (count_q[i] == CNT_ONE);
                end else if (auto_reload[i]) begin
                    count_d[i] = reload_q[i];
                end else begin
                    count_d[i] = CNT_ZERO;
                end
            end else begin
                count_d[i] = count_q[i];
            end
        end
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                count_q[i]  <= CNT_ZERO;
                reload_q[i] <= CNT_ZERO;
            end
            expire_q <= {N_CH{1'b0}};
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                count_q[i]  <= count_d[i];
                reload_q[i] <= reload_d[i];
            end
            expire_q <= expire_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_out
        assign count[g*WIDTH +: WIDTH] = count_q[g];
        assign done[g]                 = (count_q[g] == CNT_ZERO);
    end

    assign expire   = expire_q;
    assign any_done = |done;

endmodule

// File: tb/tb_riv_timer_bank.sv
// Self-checking bench for riv_timer_bank: directed scenarios plus randomized traffic
// compared every cycle against a per-channel arithmetic reference model.
module tb_riv_timer_bank;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   load;
    logic [N*W-1:0] value;
    logic [N-1:0]   enable;
    logic [N-1:0]   auto_reload;
    logic [N*W-1:0] count;
    logic [N-1:0]   done;
    logic [N-1:0]   expire;
    logic           any_done;

    riv_timer_bank #(.WIDTH(W), .N_CH(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .value       (value),
        .enable      (enable),
        .auto_reload (auto_reload),
        .count       (count),
        .done        (done),
        .expire      (expire),
        .any_done    (any_done)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: plain integers per channel.
    int unsigned m_cnt [N];
    int unsigned m_rel [N];
    bit          m_exp [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] ch(input int i);
        return count[i*W +: W];
    endfunction

    task automatic set_val(input int i, input int unsigned v);
        value[i*W +: W] = v[W-1:0];
    endtask

    task automatic model_update();
        for (int i = 0; i < N; i++) begin
            int unsigned v;
            v = value[i*W +: W];
            if (!rst_n) begin
                m_cnt[i] = 0; m_rel[i] = 0; m_exp[i] = 0;
            end else if (load[i]) begin
                m_cnt[i] = v; m_rel[i] = v; m_exp[i] = 0;
            end else if (enable[i]) begin
                m_exp[i] = (m_cnt[i] == 1);
                if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
                else if (auto_reload[i]) m_cnt[i] = m_rel[i];
                else m_cnt[i] = 0;
            end else begin
                m_exp[i] = 0;
            end
        end
    endtask

    task automatic compare_all();
        bit any;
        any = 0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("model_count%0d", i), 64'(ch(i)), 64'(m_cnt[i]));
            chk($sformatf("model_done%0d", i), 64'(done[i]), 64'(m_cnt[i] == 0));
            chk($sformatf("model_expire%0d", i), 64'(expire[i]), 64'(m_exp[i]));
            if (m_cnt[i] == 0) any = 1;
        end
        chk("model_any_done", 64'(any_done), 64'(any));
    endtask

    // One clock: model consumes the inputs seen at the edge, outputs checked 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    initial begin
        int exp_seq[$];
        int exp_pulse[$];
        for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_rel[i] = 0; m_exp[i] = 0; end
        rst_n = 1'b0; load = '0; value = '0; enable = '0; auto_reload = '0;
        step(); step();
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_done", 64'(done), 64'hF);
        chk("reset_expire", 64'(expire), 64'd0);
        chk("reset_any_done", 64'(any_done), 64'd1);
        rst_n = 1'b1;

        // One-shot ch0 from 3.
        load[0] = 1'b1; set_val(0, 3); enable[0] = 1'b1;
        step();
        chk("os_load", 64'(ch(0)), 64'd3);
        load[0] = 1'b0;
        exp_seq = '{2, 1, 0, 0};
        exp_pulse = '{0, 0, 1, 0};
        for (int k = 0; k < 4; k++) begin
            step();
            chk("os_count", 64'(ch(0)), 64'(exp_seq[k]));
            chk("os_expire", 64'(expire[0]), 64'(exp_pulse[k]));
        end
        enable[0] = 1'b0;

        // Periodic ch1 with reload 2.
        load[1] = 1'b1; set_val(1, 2); enable[1] = 1'b1; auto_reload[1] = 1'b1;
        step();
        chk("per_load", 64'(ch(1)), 64'd2);
        load[1] = 1'b0;
        exp_seq = '{1, 0, 2, 1, 0, 2, 1, 0};
        for (int k = 0; k < 8; k++) begin
            step();
            chk("per_count", 64'(ch(1)), 64'(exp_seq[k]));
            chk("per_expire", 64'(expire[1]), 64'(exp_seq[k] == 0));
        end
        enable[1] = 1'b0; auto_reload[1] = 1'b0;

        // Load and enable together on ch2.
        load[2] = 1'b1; set_val(2, 5); enable[2] = 1'b1;
        step();
        chk("le_count", 64'(ch(2)), 64'd5);
        chk("le_done", 64'(done[2]), 64'd0);
        load[2] = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("le_zero", 64'(ch(2)), 64'd0);
        chk("le_expire", 64'(expire[2]), 64'd1);
        enable[2] = 1'b0;

        // Load beats terminal decrement on ch0.
        load[0] = 1'b1; set_val(0, 4); enable[0] = 1'b1;
        step();
        load[0] = 1'b0;
        step(); step(); step();
        chk("lt_pre", 64'(ch(0)), 64'd1);
        load[0] = 1'b1; set_val(0, 7);
        step();
        chk("lt_count", 64'(ch(0)), 64'd7);
        chk("lt_expire", 64'(expire[0]), 64'd0);
        chk("lt_done", 64'(done[0]), 64'd0);
        load[0] = 1'b0; enable[0] = 1'b0;

        // Reset mid-count overrides load and enable.
        load = '1; value = {N*W{1'b1}}; enable = '1;
        step();
        load = '0;
        step(); step();
        rst_n = 1'b0; load = '1;
        step();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_done", 64'(done), 64'hF);
        chk("rst_any_done", 64'(any_done), 64'd1);
        chk("rst_expire", 64'(expire), 64'd0);
        rst_n = 1'b1; load = '0; enable = 4'b1000; auto_reload = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("p0_count", 64'(ch(3)), 64'd0);
            chk("p0_expire", 64'(expire[3]), 64'd0);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < N; i++) begin
                load[i]        = ($urandom_range(0, 9) == 0);
                enable[i]      = ($urandom_range(0, 3) != 0);
                auto_reload[i] = $urandom_range(0, 1);
                if ($urandom_range(0, 7) == 0) set_val(i, $urandom);
                else set_val(i, $urandom_range(0, 6));
            end
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
